ex_mem_skid: RTL and testbench
==============================

Name: ex_mem_skid

Overview:
- Pipeline boundary between the execute stage and the memory-access stage of the five-stage core.
- Captures the EX result (destination address, write enable, write data) and presents it to MEM one cycle later.
- Uses a valid/ready handshake with a 2-entry skid buffer, so a MEM-side stall never drops or duplicates a result and EX sees a registered (timing-clean) ready.

Parameters:
- DATA_W, 32, width of write data; equals the register-bus width.
- ADDR_W, 5, width of destination register address; equals the register-address-bus width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline flush; discards all buffered entries.
- ex_valid  in  1  EX presents a result this cycle.
- ex_ready  out  1  block can accept an EX result this cycle (registered).
- ex_wd  in  ADDR_W  destination register address from EX.
- ex_wreg  in  1  register write enable from EX.
- ex_wdata  in  DATA_W  result data from EX.
- mem_valid  out  1  head entry valid toward MEM.
- mem_ready  in  1  MEM consumes the head entry this cycle.
- mem_wd  out  ADDR_W  head destination address.
- mem_wreg  out  1  head write enable, gated by mem_valid.
- mem_wdata  out  DATA_W  head data.

Behaviour:
- Clock/reset (decided): one clock, clk; reset rst is synchronous and active-high. Sampled only on the rising edge of clk.
- Reset values: state EMPTY, both entry valids 0, ex_ready 0 in the reset cycle then 1, mem_valid 0, mem_wd 0, mem_wreg 0, mem_wdata 0.
- Storage: main entry (head, drives mem_* outputs) and skid entry.
- Accept = ex_valid & ex_ready. Issue = mem_valid & mem_ready.
- mem_* outputs come directly from main-entry registers; no combinational path from ex_* to mem_*.
- When main is invalid, mem_wd, mem_wreg and mem_wdata are forced to 0 (bubble).
- Latency: 1 cycle from accept to mem_valid when EMPTY. Throughput: 1 result per cycle while mem_ready stays high.
- ex_ready is registered: 1 in EMPTY and ONE, 0 in FULL. It never depends combinationally on mem_ready.
- State machine:
  - EMPTY: accept -> ONE, load main.
  - ONE, accept & issue -> ONE, main reloaded from ex_*.
  - ONE, accept & !issue -> FULL, load skid.
  - ONE, !accept & issue -> EMPTY.
  - ONE, neither -> hold.
  - FULL (no accept possible): issue -> ONE, skid moves to main, skid cleared. No issue -> hold; all mem_* outputs stable.
- Ordering: strictly FIFO; the skid entry is never presented before main.
- ex_valid while ex_ready=0 is ignored; EX must hold its data. Not an error.
- Flush: next state EMPTY, both valids cleared.
  - Flush has priority over a simultaneous accept; that result is dropped.
  - A simultaneous issue still counts as consumed by MEM in that cycle.
- rst has priority over flush.
- Data widths are passed through unmodified; no arithmetic.

Optional Feature:
- Macro: EX_MEM_STATS_EN.
- Defined: adds outputs stat_issued (32 bits) and stat_stalls (32 bits). Both reset to 0 on rst; neither is cleared by flush.
  - stat_issued increments on every issue.
  - stat_stalls increments every cycle mem_valid=1 & mem_ready=0.
  - Both wrap modulo 2^32 (0xFFFFFFFF -> 0).
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared defines file additions: state encodings EMSK_EMPTY=2'd0, EMSK_ONE=2'd1, EMSK_FULL=2'd2. Existing reset-enable, zero-word, register-bus and register-address-bus constants are reused.
- Optional sub-module ex_mem_entry: one register slot holding {valid, wd, wreg, wdata} with load/clear controls, instantiated twice (main, skid).
- FSM and handshake logic live in the top module.

Test Plan:
- Reset: hold rst 2 cycles with ex_valid=1 -> mem_valid=0, mem_wd/mem_wreg/mem_wdata=0. ex_ready=1 the first cycle after rst deasserts.
- Streaming: mem_ready=1, accept wd=3,wdata=0x1, wd=4,wdata=0x0 on consecutive cycles -> mem outputs show each exactly 1 cycle later, in order, no bubbles.
- Backpressure:
  - Setup: mem_ready=0, accept A(wd=5,0xAAAA) then B(wd=6,0xBBBB).
  - While stalled: ex_ready=0 after B; mem shows A stably.
  - Release mem_ready=1: A issues, then B; exactly 2 issues, no duplicate.
- Ignored input: in FULL, present C with ex_valid=1 -> C never appears on mem_*. C is accepted only after ex_ready returns to 1.
- Flush priority: FULL state, assert flush with ex_valid=1 (wd=7) -> next cycle mem_valid=0, mem_wreg=0, ex_ready=1; wd=7 never issued.
- Stats (EX_MEM_STATS_EN): 3 stall cycles then 2 issues -> stat_stalls=3, stat_issued=2. Preload counter at 0xFFFFFFFF, one issue -> 0.

Source files
------------

// File: rtl/ex_mem_skid_pkg.sv
// Shared constants and state encoding for the EX/MEM skid boundary.
package ex_mem_skid_pkg;

    localparam int          REG_BUS_W  = 32;
    localparam int          REG_ADDR_W = 5;
    localparam logic        RST_ENABLE = 1'b1;
    localparam logic [31:0] ZERO_WORD  = 32'h0;

    typedef enum logic [1:0] {
        EMSK_EMPTY = 2'd0,
        EMSK_ONE   = 2'd1,
        EMSK_FULL  = 2'd2
    } emsk_state_e;

endpackage

// File: rtl/ex_mem_entry.sv
// One buffered EX result slot {valid, wd, wreg, wdata}; clear wins over load.
module ex_mem_entry
    import ex_mem_skid_pkg::*;
#(
    parameter int DATA_W = REG_BUS_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] wd_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o
);

    logic              valid_q;
    logic [ADDR_W-1:0] wd_q;
    logic              wreg_q;
    logic [DATA_W-1:0] wdata_q;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE || clear_i) begin
            valid_q <= 1'b0;
            wd_q    <= '0;
            wreg_q  <= 1'b0;
            wdata_q <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            wd_q    <= wd_i;
            wreg_q  <= wreg_i;
            wdata_q <= wdata_i;
        end
    end

    assign valid_o = valid_q;
    assign wd_o    = wd_q;
    assign wreg_o  = wreg_q;
    assign wdata_o = wdata_q;

endmodule

// File: rtl/ex_mem_skid.sv
// EX->MEM pipeline register with a 2-entry skid buffer and registered ex_ready.
// Define EX_MEM_STATS_EN to add the stat_issued / stat_stalls counters.
module ex_mem_skid
    import ex_mem_skid_pkg::*;
#(
    parameter int DATA_W = REG_BUS_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [ADDR_W-1:0] ex_wd,
    input  logic              ex_wreg,
    input  logic [DATA_W-1:0] ex_wdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_wd,
    output logic              mem_wreg,
`ifdef EX_MEM_STATS_EN
    output logic [DATA_W-1:0] mem_wdata,
    output logic [31:0]       stat_issued,
    output logic [31:0]       stat_stalls
`else
    output logic [DATA_W-1:0] mem_wdata
`endif
);

    emsk_state_e state_q, state_d;
    logic        ex_ready_q;
    logic        accept, issue;
    logic        main_ld, main_clr, main_from_skid, skid_ld, skid_clr;

    logic              main_vld, skid_vld;
    logic [ADDR_W-1:0] main_wd, skid_wd, main_wd_d;
    logic              main_wreg, skid_wreg, main_wreg_d;
    logic [DATA_W-1:0] main_wdata, skid_wdata, main_wdata_d;

    assign accept = ex_valid & ex_ready_q;
    assign issue  = main_vld & mem_ready;

    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            state_d  = EMSK_EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                EMSK_EMPTY: begin
                    if (accept) begin
                        main_ld = 1'b1;
                        state_d = EMSK_ONE;
                    end
                end
                EMSK_ONE: begin
                    if (accept && issue) begin
                        main_ld = 1'b1;
                    end else if (accept) begin
                        skid_ld = 1'b1;
                        state_d = EMSK_FULL;
                    end else if (issue) begin
                        main_clr = 1'b1;
                        state_d  = EMSK_EMPTY;
                    end
                end
                EMSK_FULL: begin
                    if (issue) begin
                        main_ld        = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                        state_d        = EMSK_ONE;
                    end
                end
                default: state_d = EMSK_EMPTY;
            endcase
        end
    end

    // Main refills from skid when draining FULL, otherwise straight from EX.
    assign main_wd_d    = main_from_skid ? skid_wd    : ex_wd;
    assign main_wreg_d  = main_from_skid ? skid_wreg  : ex_wreg;
    assign main_wdata_d = main_from_skid ? skid_wdata : ex_wdata;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q    <= EMSK_EMPTY;
            ex_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ex_ready_q <= (state_d != EMSK_FULL);
        end
    end

    ex_mem_entry #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .load_i  (main_ld),
        .clear_i (main_clr),
        .wd_i    (main_wd_d),
        .wreg_i  (main_wreg_d),
        .wdata_i (main_wdata_d),
        .valid_o (main_vld),
        .wd_o    (main_wd),
        .wreg_o  (main_wreg),
        .wdata_o (main_wdata)
    );

    ex_mem_entry #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_ld),
        .clear_i (skid_clr),
        .wd_i    (ex_wd),
        .wreg_i  (ex_wreg),
        .wdata_i (ex_wdata),
        .valid_o (skid_vld),
        .wd_o    (skid_wd),
        .wreg_o  (skid_wreg),
        .wdata_o (skid_wdata)
    );

    assign ex_ready  = ex_ready_q;
    assign mem_valid = main_vld;
    assign mem_wd    = main_vld ? main_wd    : '0;
    assign mem_wreg  = main_vld & main_wreg;
    assign mem_wdata = main_vld ? main_wdata : '0;

`ifdef EX_MEM_STATS_EN
    logic [31:0] stat_issued_q, stat_stalls_q;

    // Counters survive flush; a same-cycle issue during flush still counts.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            stat_issued_q <= '0;
            stat_stalls_q <= '0;
        end else begin
            if (issue)
                stat_issued_q <= stat_issued_q + 32'd1;
            if (main_vld && !mem_ready)
                stat_stalls_q <= stat_stalls_q + 32'd1;
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_stalls = stat_stalls_q;
`endif

    logic unused_skid_vld;
    assign unused_skid_vld = skid_vld;

endmodule

// File: tb/tb_ex_mem_skid.sv
// Directed bench for ex_mem_skid: reset, streaming, backpressure, ignored input, flush.
module tb_ex_mem_skid;

    logic        clk = 1'b0;
    logic        rst, flush, ex_valid, ex_ready, ex_wreg;
    logic [4:0]  ex_wd, mem_wd;
    logic [31:0] ex_wdata, mem_wdata;
    logic        mem_valid, mem_ready, mem_wreg;
`ifdef EX_MEM_STATS_EN
    logic [31:0] stat_issued, stat_stalls;
    logic [31:0] iss_base, stl_base;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int n_issue = 0;
    int issue_base;

    always #5 clk = ~clk;

    ex_mem_skid dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_wd     (ex_wd),
        .ex_wreg   (ex_wreg),
        .ex_wdata  (ex_wdata),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_wd    (mem_wd),
        .mem_wreg  (mem_wreg),
`ifdef EX_MEM_STATS_EN
        .mem_wdata (mem_wdata),
        .stat_issued (stat_issued),
        .stat_stalls (stat_stalls)
`else
        .mem_wdata (mem_wdata)
`endif
    );

    always @(posedge clk)
        if (!rst && mem_valid && mem_ready) n_issue <= n_issue + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] wd, input logic [31:0] wdata);
        ex_valid = v;
        ex_wd    = wd;
        ex_wreg  = v;
        ex_wdata = wdata;
    endtask

    task automatic chk_mem(input string tag, input logic v, input logic [4:0] wd, input logic [31:0] wdata);
        chk({tag, ".valid"}, 64'(mem_valid), 64'(v));
        chk({tag, ".wd"},    64'(mem_wd),    64'(wd));
        chk({tag, ".wreg"},  64'(mem_wreg),  64'(v));
        chk({tag, ".wdata"}, 64'(mem_wdata), 64'(wdata));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; mem_ready = 1'b0;
        drive(1'b1, 5'd9, 32'h99);
        step(); step();
        chk_mem("rst", 1'b0, 5'd0, 32'h0);
        chk("rst.ex_ready", 64'(ex_ready), 64'd0);

        rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0);
        step();
        chk("post_rst.ex_ready", 64'(ex_ready), 64'd1);
        chk("post_rst.mem_valid", 64'(mem_valid), 64'd0);

        // streaming at full rate
        mem_ready = 1'b1;
        drive(1'b1, 5'd3, 32'h1);
        step();
        chk_mem("stream0", 1'b1, 5'd3, 32'h1);
        drive(1'b1, 5'd4, 32'h0);
        step();
        chk_mem("stream1", 1'b1, 5'd4, 32'h0);
        chk("stream1.ex_ready", 64'(ex_ready), 64'd1);
        drive(1'b0, 5'd0, 32'h0);
        step();
        chk_mem("stream_drain", 1'b0, 5'd0, 32'h0);

        // backpressure: A then B while stalled, then C ignored while FULL
        mem_ready = 1'b0;
        drive(1'b1, 5'd5, 32'hAAAA);
        step();
        chk_mem("bp.A", 1'b1, 5'd5, 32'hAAAA);
        chk("bp.A.ex_ready", 64'(ex_ready), 64'd1);
        drive(1'b1, 5'd6, 32'hBBBB);
        step();
        chk_mem("bp.full", 1'b1, 5'd5, 32'hAAAA);
        chk("bp.full.ex_ready", 64'(ex_ready), 64'd0);
        drive(1'b1, 5'd8, 32'hCCCC);
        step();
        chk_mem("bp.hold1", 1'b1, 5'd5, 32'hAAAA);
        step();
        chk_mem("bp.hold2", 1'b1, 5'd5, 32'hAAAA);
        chk("bp.hold2.ex_ready", 64'(ex_ready), 64'd0);

        issue_base = n_issue;
        mem_ready = 1'b1;
        step();
        chk_mem("bp.B", 1'b1, 5'd6, 32'hBBBB);
        chk("bp.B.ex_ready", 64'(ex_ready), 64'd1);
        step();
        chk_mem("bp.C", 1'b1, 5'd8, 32'hCCCC);
        drive(1'b0, 5'd0, 32'h0);
        step();
        chk_mem("bp.drain", 1'b0, 5'd0, 32'h0);
        chk("bp.issue_count", 64'(n_issue - issue_base), 64'd3);

        // flush in FULL with ex_valid high
        mem_ready = 1'b0;
        drive(1'b1, 5'd10, 32'hD);
        step();
        drive(1'b1, 5'd11, 32'hE);
        step();
        chk("fl.full.ex_ready", 64'(ex_ready), 64'd0);
        flush = 1'b1;
        drive(1'b1, 5'd7, 32'h77);
        step();
        chk_mem("fl.full", 1'b0, 5'd0, 32'h0);
        chk("fl.full.ex_ready", 64'(ex_ready), 64'd1);
        flush = 1'b0;
        drive(1'b0, 5'd0, 32'h0);
        mem_ready = 1'b1;
        step();
        chk_mem("fl.full.after", 1'b0, 5'd0, 32'h0);

        // flush beats a simultaneous accept in ONE
        mem_ready = 1'b0;
        drive(1'b1, 5'd12, 32'hF);
        step();
        chk_mem("fl.one.pre", 1'b1, 5'd12, 32'hF);
        flush = 1'b1;
        drive(1'b1, 5'd7, 32'h77);
        step();
        chk_mem("fl.one", 1'b0, 5'd0, 32'h0);
        chk("fl.one.ex_ready", 64'(ex_ready), 64'd1);
        flush = 1'b0;
        drive(1'b0, 5'd0, 32'h0);
        mem_ready = 1'b1;
        step();
        chk_mem("fl.one.after", 1'b0, 5'd0, 32'h0);

        // rst wins over flush with data buffered
        mem_ready = 1'b0;
        drive(1'b1, 5'd13, 32'h13);
        step();
        drive(1'b0, 5'd0, 32'h0);
        rst = 1'b1; flush = 1'b1;
        step();
        chk_mem("rst_flush", 1'b0, 5'd0, 32'h0);
        chk("rst_flush.ex_ready", 64'(ex_ready), 64'd0);
        rst = 1'b0; flush = 1'b0;
        step();

`ifdef EX_MEM_STATS_EN
        mem_ready = 1'b0;
        drive(1'b1, 5'd14, 32'h14);
        step();
        iss_base = stat_issued;
        stl_base = stat_stalls;
        drive(1'b0, 5'd0, 32'h0);
        step(); step(); step();
        mem_ready = 1'b1;
        drive(1'b1, 5'd15, 32'h15);
        step();
        drive(1'b0, 5'd0, 32'h0);
        step();
        chk("stat.stalls", 64'(stat_stalls - stl_base), 64'd3);
        chk("stat.issued", 64'(stat_issued - iss_base), 64'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
